phys_free_list: RTL and testbench

Physical register free list for the rename stage. It is a circular FIFO of unmapped physical register tags.
- Presents the head tag to rename as the allocation candidate.
- Pops that tag when rename consumes it.
- Pushes the old physical tag that rename returns at commit.
- Sits between rename and the commit/WB path and replaces the free list interface stub.

---
 rtl/phys_free_list.sv | 105 ++++++++++
 tb/tb_phys_free_list.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/phys_free_list.sv
// Purpose: rename-stage physical register free list; circular FIFO of unmapped tags, holds 32..63 after reset.
// Latency: head tag is presented combinationally and consumed the same cycle; a returned tag becomes allocatable next cycle.
// Backpressure: alloc_valid low means rename must stall; frees while full (without a pop) or of tag 0 are dropped and set sticky err.
// Optional: define FREELIST_CHECK_EN to add an in-list bitmap that drops and flags double frees.
module phys_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int DEPTH    = NUM_PHYS - NUM_ARCH,
    parameter int PHYS_W   = $clog2(NUM_PHYS),
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PHYS_W-1:0] alloc_phys,
    input  logic              free_en,
    input  logic [PHYS_W-1:0] free_phys,
    output logic [PTR_W:0]    free_count,
    output logic              full,
    output logic              err
);

    localparam int CNT_W = PTR_W + 1;

    logic [PHYS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              err_q;

    logic pop;
    logic push;
    logic double_free;

    // Outputs depend only on registered state; an empty list presents tag 0.
    always_comb begin
        alloc_valid = (count != '0);
        alloc_phys  = alloc_valid ? mem[head] : '0;
        full        = (count == CNT_W'(DEPTH));
        free_count  = count;
        err         = err_q;
    end

`ifdef FREELIST_CHECK_EN
    logic [NUM_PHYS-1:0] in_list;

    // A tag leaving through the head this same cycle no longer counts as present.
    always_comb begin
        double_free = in_list[free_phys] && !(pop && (alloc_phys == free_phys));
    end

    // Membership bitmap: clear the popped tag first so a same-cycle re-push wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_list <= {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};
        end else begin
            logic [NUM_PHYS-1:0] nxt;
            nxt = in_list;
            if (pop)  nxt[alloc_phys] = 1'b0;
            if (push) nxt[free_phys]  = 1'b1;
            in_list <= nxt;
        end
    end
`else
    // Without the bitmap, duplicate tags are accepted like any other.
    always_comb begin
        double_free = 1'b0;
    end
`endif

    // Accept rules: pop needs a non-empty list; push needs a nonzero tag and a free slot
    // (a same-cycle pop frees one), and must not be a detected double free.
    always_comb begin
        pop  = alloc_req && alloc_valid;
        push = free_en && (free_phys != '0) && (!full || pop) && !double_free;
    end

    // Tag storage: reset reloads the tags that are not identity-mapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_W'(NUM_ARCH + i);
            end
        end else if (push) begin
            mem[tail] <= free_phys;
        end
    end

    // Pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            err_q <= 1'b0;
        end else begin
            if (pop)  head <= head + PTR_W'(1);
            if (push) tail <= tail + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (free_en && !push) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios plus random traffic
// compared each cycle against a queue-based model of the free list.
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_phys;
    logic       free_en;
    logic [5:0] free_phys;
    logic [5:0] free_count;
    logic       full;
    logic       err;

    always #5 clk = ~clk;

    phys_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_valid(alloc_valid),
        .alloc_phys (alloc_phys),
        .free_en    (free_en),
        .free_phys  (free_phys),
        .free_count (free_count),
        .full       (full),
        .err        (err)
    );

    int nchk  = 0;
    int nfail = 0;

    // Reference model: the list contents in allocation order, plus the sticky error.
    int q[$];
    bit merr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 32; i < 64; i++) q.push_back(i);
        merr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(alloc_valid), 32'(q.size() != 0));
        chk({tag, ".phys"},  32'(alloc_phys),  (q.size() != 0) ? q[0] : 0);
        chk({tag, ".count"}, 32'(free_count), q.size());
        chk({tag, ".full"},  32'(full),       32'(q.size() == 32));
        chk({tag, ".err"},   32'(err),        32'(merr));
    endtask

    // One clock with the given inputs; model evaluated from pre-edge contents.
    task automatic do_cycle(input string tag, input bit r, input bit f, input int p);
        bit pop, push, dup;
        alloc_req = r;
        free_en   = f;
        free_phys = 6'(p);
        pop  = r && (q.size() != 0);
        dup  = 1'b0;
`ifdef FREELIST_CHECK_EN
        for (int k = 0; k < q.size(); k++)
            if (q[k] == p && !(pop && k == 0)) dup = 1'b1;
`endif
        push = f && (p != 0) && (q.size() < 32 || pop) && !dup;
        @(posedge clk);
        #1;
        if (f && !push) merr = 1'b1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(p);
        alloc_req = 1'b0;
        free_en   = 1'b0;
        free_phys = 6'd0;
        check_all(tag);
    endtask

    // Reset with random alloc/free activity to show reset overrides them.
    task automatic do_reset(input string tag);
        rst       = 1'b1;
        alloc_req = 1'($urandom_range(0, 1));
        free_en   = 1'b1;
        free_phys = 6'($urandom_range(1, 63));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        alloc_req = 1'b0;
        free_en   = 1'b0;
        free_phys = 6'd0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        rst       = 1'b1;
        alloc_req = 1'b0;
        free_en   = 1'b0;
        free_phys = 6'd0;
        model_reset();

        // Reset state.
        do_reset("reset");
        chk("reset.phys32", 32'(alloc_phys), 32);
        chk("reset.full1", 32'(full), 1);

        // Drain: tags leave in order 32..63.
        for (int i = 0; i < 32; i++) begin
            chk("drain.seq", 32'(alloc_phys), 32 + i);
            do_cycle("drain", 1'b1, 1'b0, 0);
        end
        chk("drain.empty", 32'(alloc_valid), 0);
        chk("drain.count0", 32'(free_count), 0);
        do_cycle("underflow", 1'b1, 1'b0, 0);
        chk("underflow.err0", 32'(err), 0);

        // Empty: simultaneous alloc and free of 5; no bypass.
        do_cycle("empty_push", 1'b1, 1'b1, 5);
        chk("empty_push.phys5", 32'(alloc_phys), 5);
        chk("empty_push.count1", 32'(free_count), 1);

        // Full: overflow dropped, then pop+push accepted.
        do_reset("reset2");
        do_cycle("overflow", 1'b0, 1'b1, 7);
        chk("overflow.err1", 32'(err), 1);
        chk("overflow.count32", 32'(free_count), 32);
        chk("fullswap.pre", 32'(alloc_phys), 32);
        do_cycle("fullswap", 1'b1, 1'b1, 7);
        chk("fullswap.head33", 32'(alloc_phys), 33);
        chk("fullswap.count32", 32'(free_count), 32);

        // Tag 0 is never accepted; later legal frees still are.
        do_reset("reset3");
        do_cycle("pop1", 1'b1, 1'b0, 0);
        do_cycle("tag0", 1'b0, 1'b1, 0);
        chk("tag0.count31", 32'(free_count), 31);
        chk("tag0.err1", 32'(err), 1);
        do_cycle("after_tag0", 1'b0, 1'b1, 9);
        chk("after_tag0.count32", 32'(free_count), 32);

        // Wrap-around: 8 pre-pops, then 40 pop+push cycles of tags 1..40.
        do_reset("reset4");
        for (int i = 0; i < 8; i++) do_cycle("prepop", 1'b1, 1'b0, 0);
        for (int k = 0; k < 40; k++) begin
            chk("wrap.order", 32'(alloc_phys), (k < 24) ? 40 + k : k - 23);
            do_cycle("wrap", 1'b1, 1'b1, k + 1);
        end
        chk("wrap.count24", 32'(free_count), 24);

`ifdef FREELIST_CHECK_EN
        // Double free detection.
        do_reset("reset5");
        do_cycle("dpop", 1'b1, 1'b0, 0);
        do_cycle("dfree40", 1'b0, 1'b1, 40);
        chk("dfree40.err1", 32'(err), 1);
        chk("dfree40.count31", 32'(free_count), 31);
        do_cycle("free32", 1'b0, 1'b1, 32);
        chk("free32.count32", 32'(free_count), 32);
`endif

        // Mid-run reset reinitialises everything.
        do_cycle("pre_rst", 1'b1, 1'b1, 0);
        do_reset("midrst");
        chk("midrst.phys32", 32'(alloc_phys), 32);
        chk("midrst.err0", 32'(err), 0);

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            int p;
            bit r, f;
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_rst");
            end else begin
                r = ($urandom_range(0, 99) < 50);
                f = ($urandom_range(0, 99) < 50);
                p = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 63));
                do_cycle("rnd", r, f, p);
            end
        end

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end

endmodule
